// File: rtl/mux8_rr_arbiter_pkg.sv
// rtl/mux8_rr_arbiter_pkg.sv - mux8_arb_pkg: widths, FSM state encoding and one-hot select helper
package mux8_arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   // Raw state codes kept as plain constants so legacy code can compare against them directly
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   typedef enum logic [0:0] {
      IDLE = ST_IDLE,
      HOLD = ST_HOLD
   } arb_state_e;

   // One-hot grant vector for a select code
   function automatic logic [N_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] s);
      logic [N_REQ-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// rtl/mux8_rr_arbiter_if.sv - requester/arbiter bundle for the shared 8:1 select lane
interface mux8_rr_arbiter_if;
   import mux8_arb_pkg::*;

   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] data_in;
   logic [N_REQ-1:0] gnt;
   logic [SEL_W-1:0] sel;
   logic             data_out;
   logic             data_valid;
   logic             busy;
   logic             preempt;

   // Requester side: raises requests and supplies data bits
   modport master (
      output req, data_in,
      input  gnt, sel, data_out, data_valid, busy, preempt
   );

   // Arbiter side
   modport slave (
      input  req, data_in,
      output gnt, sel, data_out, data_valid, busy, preempt
   );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// rtl/mux8_rr_arbiter_rr_pick.sv - rr_pick: combinational rotate-priority encoder
module rr_pick
   import mux8_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] pointer,
   output logic [SEL_W-1:0] winner,
   output logic             any
);

   // Scan offsets from farthest to nearest so the requester closest after the pointer wins;
   // offset N_REQ wraps back onto the pointer itself, giving the last grantee lowest priority
   always_comb begin
      winner = '0;
      any    = |req;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[pointer + SEL_W'(k)]) begin
            winner = pointer + SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin grant/select sequencer for the 8:1 lane; ARB_TIMEOUT_EN adds forced release
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int MAX_BEATS = 16
) (
   input logic               clk,
   input logic               rst_n,
   mux8_rr_arbiter_if.slave  bus
);

   if (MAX_BEATS < 2) begin : g_bad_max_beats
      $error("MAX_BEATS must be at least 2");
   end

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic             data_out_q, data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             busy_q, busy_d;
   logic             preempt_q, preempt_d;

   logic [SEL_W-1:0] pick_winner;
   logic             pick_any;
   logic             hold_req;
   logic             force_release;

   rr_pick u_pick (
      .req     (bus.req),
      .pointer (ptr_q),
      .winner  (pick_winner),
      .any     (pick_any)
   );

   assign hold_req = bus.req[sel_q];

`ifdef ARB_TIMEOUT_EN
   localparam int BEAT_W = $clog2(MAX_BEATS);

   logic [BEAT_W-1:0] beat_q, beat_d;

   // Last permitted HOLD cycle reached while the grantee still wants the lane
   assign force_release = hold_req && (beat_q == BEAT_W'(MAX_BEATS - 1));

   // Beat counter restarts on every grant and advances once per HOLD cycle
   always_comb begin
      beat_d = beat_q;
      if (state_q == IDLE) begin
         beat_d = '0;
      end else if (hold_req && !force_release) begin
         beat_d = beat_q + 1'b1;
      end
   end

   // Beat counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         beat_q <= '0;
      end else begin
         beat_q <= beat_d;
      end
   end
`else
   assign force_release = 1'b0;
`endif

   // IDLE arbitrates and grants; HOLD forwards data until release (or forced release)
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      sel_d        = sel_q;
      ptr_d        = ptr_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      busy_d       = busy_q;
      preempt_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d      = HOLD;
               gnt_d        = sel_onehot(pick_winner);
               sel_d        = pick_winner;
               busy_d       = 1'b1;
               data_valid_d = 1'b0;
            end
         end
         HOLD: begin
            if (!hold_req || force_release) begin
               // sel stays on the last grantee so the mux keeps a stable select
               state_d      = IDLE;
               gnt_d        = '0;
               busy_d       = 1'b0;
               data_valid_d = 1'b0;
               ptr_d        = sel_q;
               preempt_d    = force_release;
            end else begin
               data_out_d   = bus.data_in[sel_q];
               data_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Arbiter state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         sel_q        <= '0;
         ptr_q        <= SEL_W'(N_REQ - 1);
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         preempt_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         sel_q        <= sel_d;
         ptr_q        <= ptr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         busy_q       <= busy_d;
         preempt_q    <= preempt_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.sel        = sel_q;
   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.busy       = busy_q;
   assign bus.preempt    = preempt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb/tb_mux8_rr_arbiter.sv - directed self-checking bench for mux8_rr_arbiter
module tb_mux8_rr_arbiter;
   import mux8_arb_pkg::*;

`ifdef ARB_TIMEOUT_EN
   localparam int TB_MAX_BEATS = 4;
`else
   localparam int TB_MAX_BEATS = 16;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   mux8_rr_arbiter_if arb_if ();

   mux8_rr_arbiter #(.MAX_BEATS(TB_MAX_BEATS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (arb_if)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      arb_if.req = '0;
      arb_if.data_in = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (arb_if.gnt !== 8'h00) begin
         bad++; $display("FAIL reset_gnt: got %h want 00", arb_if.gnt);
      end
      total++;
      if (arb_if.sel !== 3'd0) begin
         bad++; $display("FAIL reset_sel: got %0d want 0", arb_if.sel);
      end
      total++;
      if ({arb_if.data_out, arb_if.data_valid, arb_if.busy, arb_if.preempt} !== 4'b0000) begin
         bad++; $display("FAIL reset_flags: got %b want 0000",
                         {arb_if.data_out, arb_if.data_valid, arb_if.busy, arb_if.preempt});
      end
   endtask

   task automatic test_single();
      arb_if.req = 8'h01;
      arb_if.data_in = 8'h01;
      tick();
      total++;
      if ({arb_if.gnt, arb_if.sel, arb_if.busy, arb_if.data_valid} !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
         bad++; $display("FAIL single_grant: got gnt=%h sel=%0d busy=%b dv=%b want 01/0/1/0",
                         arb_if.gnt, arb_if.sel, arb_if.busy, arb_if.data_valid);
      end
      tick();
      total++;
      if ({arb_if.data_out, arb_if.data_valid} !== 2'b11) begin
         bad++; $display("FAIL single_data: got dout=%b dv=%b want 1/1", arb_if.data_out, arb_if.data_valid);
      end
      arb_if.req = 8'h00;
      tick();
      total++;
      if ({arb_if.gnt, arb_if.sel, arb_if.busy, arb_if.data_valid} !== {8'h00, 3'd0, 1'b0, 1'b0}) begin
         bad++; $display("FAIL single_release: got gnt=%h sel=%0d busy=%b dv=%b want 00/0/0/0",
                         arb_if.gnt, arb_if.sel, arb_if.busy, arb_if.data_valid);
      end
   endtask

   task automatic test_rotation();
      logic [7:0] pat;
      logic [7:0] oh;
      int         exp_id;
      do_reset();
      pat = 8'b0110_1001;
      arb_if.data_in = pat;
      arb_if.req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         exp_id = i % 8;
         oh = 8'h01 << exp_id;
         tick();
         total++;
         if ({arb_if.gnt, arb_if.sel, arb_if.busy} !== {oh, 3'(exp_id), 1'b1}) begin
            bad++; $display("FAIL rot_grant[%0d]: got gnt=%h sel=%0d busy=%b want %h/%0d/1",
                            i, arb_if.gnt, arb_if.sel, arb_if.busy, oh, exp_id);
         end
         tick();
         total++;
         if ({arb_if.gnt, arb_if.data_valid, arb_if.data_out} !== {oh, 1'b1, pat[exp_id]}) begin
            bad++; $display("FAIL rot_data[%0d]: got gnt=%h dv=%b dout=%b want %h/1/%b",
                            i, arb_if.gnt, arb_if.data_valid, arb_if.data_out, oh, pat[exp_id]);
         end
         arb_if.req[exp_id] = 1'b0;
         tick();
         total++;
         if ({arb_if.gnt, arb_if.busy, arb_if.data_valid} !== {8'h00, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rot_gap[%0d]: got gnt=%h busy=%b dv=%b want 00/0/0",
                            i, arb_if.gnt, arb_if.busy, arb_if.data_valid);
         end
         arb_if.req[exp_id] = 1'b1;
      end
      arb_if.req = 8'h00;
      tick();
   endtask

   task automatic test_hold_other();
      do_reset();
      arb_if.data_in = 8'hFF;
      arb_if.req = 8'h08;
      tick();
      total++;
      if (arb_if.gnt !== 8'h08) begin
         bad++; $display("FAIL hold_first: got %h want 08", arb_if.gnt);
      end
      arb_if.req = 8'h28;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if ({arb_if.gnt, arb_if.sel} !== {8'h08, 3'd3}) begin
            bad++; $display("FAIL hold_keep[%0d]: got gnt=%h sel=%0d want 08/3", i, arb_if.gnt, arb_if.sel);
         end
      end
      arb_if.req = 8'h20;
      tick();
      total++;
      if (arb_if.gnt !== 8'h00) begin
         bad++; $display("FAIL hold_drop: got %h want 00", arb_if.gnt);
      end
      tick();
      total++;
      if ({arb_if.gnt, arb_if.sel} !== {8'h20, 3'd5}) begin
         bad++; $display("FAIL hold_next: got gnt=%h sel=%0d want 20/5", arb_if.gnt, arb_if.sel);
      end
      arb_if.req = 8'h00;
      tick();
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      arb_if.req = 8'h10;
      arb_if.data_in = 8'h10;
      tick();
      total++;
      if (arb_if.gnt !== 8'h10) begin
         bad++; $display("FAIL mid_grant: got %h want 10", arb_if.gnt);
      end
      tick();
      total++;
      if ({arb_if.data_valid, arb_if.data_out} !== 2'b11) begin
         bad++; $display("FAIL mid_data: got dv=%b dout=%b want 1/1", arb_if.data_valid, arb_if.data_out);
      end
      rst_n = 1'b0;
      tick();
      total++;
      if ({arb_if.gnt, arb_if.sel, arb_if.data_valid, arb_if.busy, arb_if.data_out} !== {8'h00, 3'd0, 3'b000}) begin
         bad++; $display("FAIL mid_reset: got gnt=%h sel=%0d dv=%b busy=%b dout=%b want 00/0/0/0/0",
                         arb_if.gnt, arb_if.sel, arb_if.data_valid, arb_if.busy, arb_if.data_out);
      end
      rst_n = 1'b1;
      arb_if.req = 8'h60;
      arb_if.data_in = 8'h20;
      tick();
      total++;
      if ({arb_if.gnt, arb_if.sel, arb_if.data_valid} !== {8'h20, 3'd5, 1'b0}) begin
         bad++; $display("FAIL mid_regrant: got gnt=%h sel=%0d dv=%b want 20/5/0",
                         arb_if.gnt, arb_if.sel, arb_if.data_valid);
      end
      tick();
      total++;
      if ({arb_if.data_valid, arb_if.data_out} !== 2'b11) begin
         bad++; $display("FAIL mid_redata: got dv=%b dout=%b want 1/1", arb_if.data_valid, arb_if.data_out);
      end
      arb_if.req = 8'h00;
      tick();
   endtask

   task automatic test_drop_same_cycle();
      arb_if.req = 8'h04;
      tick();
      total++;
      if ({arb_if.gnt, arb_if.busy} !== {8'h04, 1'b1}) begin
         bad++; $display("FAIL drop_grant: got gnt=%h busy=%b want 04/1", arb_if.gnt, arb_if.busy);
      end
      arb_if.req = 8'h00;
      tick();
      total++;
      if ({arb_if.gnt, arb_if.busy, arb_if.data_valid} !== {8'h00, 1'b0, 1'b0}) begin
         bad++; $display("FAIL drop_release: got gnt=%h busy=%b dv=%b want 00/0/0",
                         arb_if.gnt, arb_if.busy, arb_if.data_valid);
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [7:0] exp_gnt;
      do_reset();
      arb_if.req = 8'h06;
      for (int g = 0; g < 4; g++) begin
         exp_gnt = (g % 2 == 0) ? 8'h02 : 8'h04;
         for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if ({arb_if.gnt, arb_if.preempt} !== {exp_gnt, 1'b0}) begin
               bad++; $display("FAIL to_hold[%0d.%0d]: got gnt=%h preempt=%b want %h/0",
                               g, c, arb_if.gnt, arb_if.preempt, exp_gnt);
            end
         end
         tick();
         total++;
         if ({arb_if.gnt, arb_if.preempt, arb_if.busy} !== {8'h00, 1'b1, 1'b0}) begin
            bad++; $display("FAIL to_release[%0d]: got gnt=%h preempt=%b busy=%b want 00/1/0",
                            g, arb_if.gnt, arb_if.preempt, arb_if.busy);
         end
      end
      arb_if.req = 8'h00;
      tick();
   endtask
`else
   task automatic test_long_hold();
      do_reset();
      arb_if.req = 8'h02;
      tick();
      total++;
      if (arb_if.gnt !== 8'h02) begin
         bad++; $display("FAIL long_grant: got %h want 02", arb_if.gnt);
      end
      for (int c = 0; c < 30; c++) begin
         tick();
         total++;
         if ({arb_if.gnt, arb_if.preempt, arb_if.busy} !== {8'h02, 1'b0, 1'b1}) begin
            bad++; $display("FAIL long_hold[%0d]: got gnt=%h preempt=%b busy=%b want 02/0/1",
                            c, arb_if.gnt, arb_if.preempt, arb_if.busy);
         end
      end
      arb_if.req = 8'h00;
      tick();
   endtask
`endif

   initial begin
      arb_if.req = '0;
      arb_if.data_in = '0;
      test_reset();
      test_single();
      test_rotation();
      test_hold_other();
      test_reset_mid_hold();
      test_drop_same_cycle();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`else
      test_long_hold();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter and sequencer for the 8:1 bit-select datapath. Shares one output lane among eight requesters: picks one requester, drives the registered 3-bit select, forwards the granted requester's data bit, and holds the grant until that requester releases it. Sits directly in front of the 8:1 select mux and replaces free-running select logic.

## Interface
- MAX_BEATS, 16, maximum consecutive HOLD cycles per grant when the timeout feature is compiled in (≥2; ignored otherwise)
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- req  in  8  per-requester request, level-held while the requester wants the lane
- data_in  in  8  per-requester data bit; bit i belongs to requester i
- gnt  out  8  one-hot grant, registered
- sel  out  3  registered select code of the current or last grantee; drives the mux select
- data_out  out  1  registered copy of data_in[sel] while granted
- data_valid  out  1  high when data_out carries granted data
- busy  out  1  high in HOLD
- preempt  out  1  one-cycle pulse on forced release (timeout); constant 0 when the feature is compiled out

## Operation
- Reset (rst_n low at a clk edge): state=IDLE, gnt=0, sel=0, data_out=0, data_valid=0, busy=0, preempt=0, beat count=0, last-grant pointer=7, so requester 0 has top priority first.
- IDLE: if req==0, stay. Otherwise pick the first set req bit searching upward from pointer+1 modulo 8. Next edge: gnt=onehot(winner), sel=winner, busy=1, state=HOLD.
- HOLD: while req[sel]==1, stay; each cycle data_out<=data_in[sel], data_valid<=1.
- Release: in HOLD with req[sel]==0 at an edge: gnt=0, busy=0, data_valid=0, pointer=sel, state=IDLE. sel keeps its value.
- Requests from non-granted requesters are never lost; they persist as levels and are arbitrated in IDLE.
- Simultaneous requests: strict rotation order from pointer+1; the winner of the last grant has lowest priority at the next arbitration.
- Requester dropping req in the same cycle it is picked still receives the grant; the grant releases on the following edge (1 HOLD cycle).
- Reset mid-HOLD: all outputs return to reset values on that edge; no data_valid is produced afterwards.

## Timing
- Request to grant: 1 cycle (req seen at edge n in IDLE → gnt/sel valid after edge n+1).
- Data latency: data_out at edge n+1 equals data_in[sel] sampled at edge n; data_valid aligned with data_out.
- Minimum gap between grants: 1 IDLE cycle, so back-to-back grants to different requesters are spaced by exactly one non-busy cycle.
- Worst-case wait (timeout compiled in): 7 × (MAX_BEATS + 1) cycles.

## Configuration
- ARB_TIMEOUT_EN defined: beat counter width $clog2(MAX_BEATS) counts HOLD cycles; when count reaches MAX_BEATS−1 and req[sel] is still 1, the next edge forces release exactly as a normal release, and preempt pulses for that one cycle. Counter clears on every entry to HOLD. If no other requester is pending, the same requester is re-granted after the 1-cycle gap.
- Not defined: no counter; grants hold indefinitely; preempt tied to 0.

## Structure
- Shared package mux8_arb_pkg: N_REQ=8, SEL_W=3, state enum {IDLE, HOLD}, and a function for the one-hot encode of the select code.
- One sub-module: rr_pick — combinational rotate-priority encoder (inputs req[7:0], pointer[2:0]; outputs winner[2:0], any).

## Test plan
- Reset then req=8'b0000_0001, data_in[0]=1 → gnt=8'h01, sel=0 one cycle later; data_out=1, data_valid=1 the next cycle.
- req=8'hFF held, each grantee dropping req after 2 HOLD cycles → grant order 0,1,2,…,7,0 with one idle cycle between grants.
- Granted requester 3 holding; req[5] rises → no change until req[3] drops; then gnt=8'h20 two cycles after the drop.
- ARB_TIMEOUT_EN, MAX_BEATS=4, req=8'h06 held → gnt alternates 0x02/0x04 every 4 HOLD cycles, preempt pulses at each switch.
- rst_n low during HOLD with gnt=8'h10 → next cycle gnt=0, data_valid=0, sel=0; first grant after reset goes to lowest set req bit.
